// File: rtl/reservoir_pkg.sv
// reservoir_pkg: level-width, thermometer-check and popcount helpers shared by reservoir blocks.
package reservoir_pkg;

    localparam int MAX_SENS = 8;

    typedef logic [MAX_SENS-1:0] sens_t;

    function automatic int level_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Callers zero-extend narrower sensor vectors, so unused upper bits never break the code.
    function automatic logic thermo_valid(input sens_t v);
        logic ok;
        ok = 1'b1;
        for (int k = 1; k < MAX_SENS; k++)
            if (v[k] && !v[k-1]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] popcount(input sens_t v);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < MAX_SENS; k++) c = c + 4'(v[k]);
        return c;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: candidate/stable-counter tracker raising o_commit at the edge
// where the input has held one value for DEBOUNCE consecutive edges.
module sensor_debounce #(
    parameter int W        = 3,
    parameter int DEBOUNCE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_s,
    output logic         o_commit
);

    logic [W-1:0] r_cand;
    logic [3:0]   r_cnt;
    logic         w_same;

    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_deb
        $error("sensor_debounce: DEBOUNCE out of range 1..15");
    end

    assign w_same = (i_s == r_cand);
    // Fires only on the edge that brings the counter to DEBOUNCE; saturated holds never re-fire.
    assign o_commit = w_same ? (({1'b0, r_cnt} + 5'd1) == 5'(DEBOUNCE)) : (DEBOUNCE == 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (!w_same) begin
            r_cand <= i_s;
            r_cnt  <= 4'd1;
        end else if (r_cnt != 4'(DEBOUNCE)) begin
            r_cnt  <= r_cnt + 4'd1;
        end

endmodule

// File: rtl/reservoir_ctrl_n.sv
// reservoir_ctrl_n: debounced thermometer level sensing driving nominal and
// supplemental flow valves, with a sticky fault for non-thermometer codes.
module reservoir_ctrl_n
    import reservoir_pkg::*;
#(
    parameter int NUM_SENS = 3,
    parameter int DEBOUNCE = 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_SENS-1:0]                 s,
    output logic [NUM_SENS-1:0]                 fr,
    output logic                                dfr,
    output logic [level_width(NUM_SENS)-1:0]    level,
    output logic                                fault
);

    localparam int LW = level_width(NUM_SENS);

    logic [LW-1:0] r_level;
    logic [LW-1:0] w_new;
    logic          r_dfr;
    logic          r_fault;
    logic          w_commit;
    logic          w_valid;

    if (NUM_SENS < 2 || NUM_SENS > MAX_SENS) begin : g_bad_sens
        $error("reservoir_ctrl_n: NUM_SENS out of range 2..8");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_deb
        $error("reservoir_ctrl_n: DEBOUNCE out of range 1..15");
    end

    sensor_debounce #(
        .W        (NUM_SENS),
        .DEBOUNCE (DEBOUNCE)
    ) u_deb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_s      (s),
        .o_commit (w_commit)
    );

    assign w_valid = thermo_valid(MAX_SENS'(s));
    assign w_new   = LW'(popcount(MAX_SENS'(s)));

    // Empty/full take precedence over direction when choosing the supplemental valve.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_level <= '0;
            r_dfr   <= 1'b1;
            r_fault <= 1'b0;
        end else if (w_commit) begin
            r_fault <= !w_valid;
            if (w_valid && w_new != r_level) begin
                r_level <= w_new;
                r_dfr   <= (w_new == '0) || (int'(w_new) != NUM_SENS && w_new < r_level);
            end
        end

    always_comb begin
        fr = '0;
        for (int i = 0; i < NUM_SENS; i++) fr[i] = int'(r_level) < NUM_SENS - i;
    end

    assign level = r_level;
    assign dfr   = r_dfr;
    assign fault = r_fault;

endmodule

// File: tb/tb_reservoir_ctrl_n.sv
// tb_reservoir_ctrl_n: ten parameter variants driven in lockstep; a queue-based
// scoreboard compares every edge against a run-length reference model.
module tb_reservoir_ctrl_n;

    localparam int NI = 10;
    localparam int NS [NI] = '{3, 4, 3, 3, 2, 2, 5, 5, 8, 8};
    localparam int DB [NI] = '{1, 1, 3, 2, 1, 4, 1, 4, 1, 4};

    localparam logic [2:0] SEQ29 [5] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b011};
    localparam logic [2:0] FR29  [5] = '{3'b111, 3'b011, 3'b001, 3'b000, 3'b001};
    localparam int         DF29  [5] = '{1, 0, 0, 0, 1};

    typedef struct packed {
        logic [NI-1:0][7:0] fr;
        logic [NI-1:0][3:0] lv;
        logic [NI-1:0]      dfr;
        logic [NI-1:0]      flt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] s_v   [NI];
    logic [7:0] nxt   [NI];
    logic [7:0] fr_v  [NI];
    logic [3:0] lv_v  [NI];
    logic       dfr_v [NI];
    logic       flt_v [NI];

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q[$];

    int m_lvl [NI];
    int m_dfr [NI];
    int m_flt [NI];
    int m_prev[NI];
    int m_run [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [NS[g]-1:0]             fr_l;
        logic [$clog2(NS[g]+1)-1:0]   lv_l;
        reservoir_ctrl_n #(
            .NUM_SENS (NS[g]),
            .DEBOUNCE (DB[g])
        ) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .s       (s_v[g][NS[g]-1:0]),
            .fr      (fr_l),
            .dfr     (dfr_v[g]),
            .level   (lv_l),
            .fault   (flt_v[g])
        );
        assign fr_v[g] = 8'(fr_l);
        assign lv_v[g] = 4'(lv_l);
    end

    function automatic int pop8(input logic [7:0] v);
        int c;
        c = 0;
        for (int k = 0; k < 8; k++) c += int'(v[k]);
        return c;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_lvl[g]  = 0;
            m_dfr[g]  = 1;
            m_flt[g]  = 0;
            m_prev[g] = -1;
            m_run[g]  = 0;
        end
    endtask

    // Commit happens when the run of identical samples reaches exactly DEBOUNCE.
    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            int v, lp;
            v = int'(s_v[g]) & ((1 << NS[g]) - 1);
            m_run[g] = (v == m_prev[g]) ? m_run[g] + 1 : 1;
            if (m_run[g] > 100) m_run[g] = 100;
            m_prev[g] = v;
            if (m_run[g] == DB[g]) begin
                lp = pop8(8'(v));
                if (v == (1 << lp) - 1) begin
                    m_flt[g] = 0;
                    if (lp != m_lvl[g]) begin
                        m_dfr[g] = (lp == 0) ? 1 : (lp == NS[g]) ? 0 : (lp < m_lvl[g]) ? 1 : 0;
                        m_lvl[g] = lp;
                    end
                end else begin
                    m_flt[g] = 1;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int g = 0; g < NI; g++) begin
            e.fr[g]  = 8'((1 << (NS[g] - m_lvl[g])) - 1);
            e.lv[g]  = 4'(m_lvl[g]);
            e.dfr[g] = 1'(m_dfr[g]);
            e.flt[g] = 1'(m_flt[g]);
        end
        q.push_back(e);
    endtask

    task automatic drive();
        @(negedge clk);
        s_v = nxt;
        if (reset_n) model_step();
        else model_reset();
        push_exp();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d need %0d", nm, act, exp_v);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int g = 0; g < NI; g++) begin
                n_tests++;
                if ({fr_v[g], lv_v[g], dfr_v[g], flt_v[g]} !== {e.fr[g], e.lv[g], e.dfr[g], e.flt[g]}) begin
                    n_fail++;
                    $display("FAIL sb inst%0d N=%0d D=%0d s=%b: fr/lvl/dfr/flt got %b/%0d/%b/%b need %b/%0d/%b/%b",
                             g, NS[g], DB[g], s_v[g], fr_v[g], lv_v[g], dfr_v[g], flt_v[g],
                             e.fr[g], e.lv[g], e.dfr[g], e.flt[g]);
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < NI; g++) begin
            nxt[g] = '0;
            s_v[g] = '0;
        end
        model_reset();
        repeat (2) drive();
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            nxt[0] = 8'(SEQ29[i]);
            drive();
            chk($sformatf("rise_fall_fr[%0d]", i), int'(fr_v[0]), int'(FR29[i]));
            chk($sformatf("rise_fall_dfr[%0d]", i), int'(dfr_v[0]), DF29[i]);
        end

        chk("pre_reset_level", int'(lv_v[0]), 2);
        reset_n = 1'b0;
        #1;
        chk("async_reset_fr", int'(fr_v[0]), 7);
        chk("async_reset_dfr", int'(dfr_v[0]), 1);
        chk("async_reset_level", int'(lv_v[0]), 0);
        chk("async_reset_fault", int'(flt_v[0]), 0);
        drive();
        reset_n = 1'b1;
        drive();

        nxt[1] = 8'b0111;
        drive();
        chk("jump_level", int'(lv_v[1]), 3);
        chk("jump_fr", int'(fr_v[1]), 1);
        chk("jump_dfr", int'(dfr_v[1]), 0);

        nxt[2] = 8'b001;
        repeat (3) drive();
        chk("glitch_base_level", int'(lv_v[2]), 1);
        nxt[2] = 8'b011;
        drive();
        chk("glitch_e1_level", int'(lv_v[2]), 1);
        drive();
        chk("glitch_e2_level", int'(lv_v[2]), 1);
        nxt[2] = 8'b001;
        drive();
        chk("glitch_back_level", int'(lv_v[2]), 1);
        nxt[2] = 8'b011;
        drive();
        drive();
        chk("hold_e2_level", int'(lv_v[2]), 1);
        drive();
        chk("hold_e3_level", int'(lv_v[2]), 2);

        nxt[3] = 8'b011;
        repeat (2) drive();
        chk("fault_base_level", int'(lv_v[3]), 2);
        nxt[3] = 8'b101;
        drive();
        chk("fault_e1_fault", int'(flt_v[3]), 0);
        drive();
        chk("fault_set", int'(flt_v[3]), 1);
        chk("fault_level", int'(lv_v[3]), 2);
        chk("fault_dfr", int'(dfr_v[3]), 0);
        nxt[3] = 8'b011;
        drive();
        chk("fault_sticky", int'(flt_v[3]), 1);
        drive();
        chk("fault_clear", int'(flt_v[3]), 0);
        chk("fault_clear_level", int'(lv_v[3]), 2);

        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NI; g++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r >= 8) nxt[g] = 8'($urandom);
                else if (r >= 5) nxt[g] = 8'((1 << $urandom_range(0, NS[g])) - 1);
            end
            drive();
            if (c == 1500) begin
                reset_n = 1'b0;
                drive();
                reset_n = 1'b1;
            end
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reservoir_ctrl_n.md
RESERVOIR_CTRL_N -- requirements
Module: reservoir_ctrl_n

Interface
REQ-001 The block SHALL have parameter NUM_SENS, default 3, giving the number of level sensors (legal 2..8).
REQ-002 The block SHALL have parameter DEBOUNCE, default 1, giving the consecutive equal samples needed to commit (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port s, input, NUM_SENS bits, sensor vector, synchronous to clk; s[k]=1 means water is above sensor k.
REQ-006 The block SHALL have port fr, output, NUM_SENS bits, nominal flow-valve enables.
REQ-007 The block SHALL have port dfr, output, 1 bit, supplemental flow-valve enable.
REQ-008 The block SHALL have port level, output, $clog2(NUM_SENS+1) bits, the committed level L (0..NUM_SENS).
REQ-009 The block SHALL have port fault, output, 1 bit, flagging a committed non-thermometer sensor code.

Function
REQ-010 A sensor code SHALL be valid only when it is thermometer-coded: s[k]=1 implies s[j]=1 for all j<k. All-zero and all-one are valid.
REQ-011 For a valid code, the sample level SHALL be the popcount of s.
REQ-012 A candidate register and a saturating stable counter SHALL track s.
- s differs from the candidate: the candidate loads s and the counter loads 1.
- s equals the candidate: the counter increments, saturating at DEBOUNCE.
REQ-013 A commit SHALL occur at the edge where s has equalled one value for DEBOUNCE consecutive edges, that edge included. With DEBOUNCE=1, a change in s commits on the first edge.
REQ-014 A commit of a valid code whose sample level L' differs from L SHALL load L<=L' in one step, including multi-level jumps.
REQ-015 A commit of an invalid code SHALL set fault=1 and leave L and dfr unchanged.
REQ-016 fault SHALL stay set until the next commit of a valid code, which clears it at that edge.
REQ-017 fr SHALL be a combinational decode of registered L only: fr[i]=1 iff L < NUM_SENS-i.
- L=0: all fr bits asserted.
- L=NUM_SENS: all fr bits deasserted.
REQ-018 dfr SHALL be registered and updated only on a valid commit that changes L, by priority:
- L'=0: dfr=1.
- L'=NUM_SENS: dfr=0.
- L'<L: dfr=1.
- L'>L: dfr=0.
REQ-019 A valid commit with L'=L SHALL leave dfr unchanged and clear fault.
REQ-020 The block SHALL commit at most once per change of s. While the counter is saturated, repeated equal samples SHALL cause no re-evaluation.
REQ-021 A glitch shorter than DEBOUNCE edges SHALL NOT change L, dfr or fault.
REQ-022 level SHALL always equal L. No X SHALL propagate to outputs for any s value.

Reset
REQ-023 While reset_n=0, the block SHALL immediately force: L=0, dfr=1, fault=0, all fr bits=1, candidate=0, counter=0. This applies mid-operation as well.
REQ-024 After reset_n rises, s SHALL be processed as a new candidate from the first rising clk edge.

Structure
REQ-025 Package reservoir_pkg SHALL hold the level-width function, the thermometer-valid function and the popcount function, shared with future reservoir blocks.
REQ-026 Debounce (candidate, counter, commit strobe) SHALL be the sub-module sensor_debounce, parametrised by width and DEBOUNCE. Level, dfr and fault logic SHALL reside in reservoir_ctrl_n.
REQ-027 The implementation SHALL be synthesizable, with elaboration assertions rejecting out-of-range parameters.

Verification
REQ-028 The bench SHALL cover reset: NUM_SENS=3; assert reset_n=0 mid-run with L=2 -> fr=3'b111, dfr=1, level=0, fault=0 without waiting for a clk edge.
REQ-029 The bench SHALL cover a rising then falling sequence: NUM_SENS=3, DEBOUNCE=1; s=000,001,011,111,011 on successive edges -> fr/dfr after each = 111/1, 011/0, 001/0, 000/0, 001/1.
REQ-030 The bench SHALL cover a jump: NUM_SENS=4, DEBOUNCE=1, L=0; s=0111 -> level=3 at the next edge, fr=4'b0001, dfr=0.
REQ-031 The bench SHALL cover a glitch: DEBOUNCE=3, L=1 (s=001); s=011 for 2 edges then 001 -> level stays 1. Then s=011 held for 3 edges -> level=2 at the third edge.
REQ-032 The bench SHALL cover fault:
- NUM_SENS=3, DEBOUNCE=2, L=2; s=101 held 2 edges -> fault=1, level=2, dfr unchanged.
- Then s=011 held 2 edges -> fault=0, level=2.
REQ-033 The bench SHALL run a random sweep over NUM_SENS in {2,5,8} and DEBOUNCE in {1,4} against a scoreboard model, checking REQ-017 and REQ-018 at every edge.
